// File: rtl/mips_pkg.sv
// Shared fetch-stage constants, RUN/HALT state encoding and PC helpers.
// No logic of its own; imported by the fetch control and its IF/ID register.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] PC_ALIGN  = 32'hFFFF_FFFC;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  // Branch targets are forced onto a word boundary before reaching the PC.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds; one-cycle latency.
// No backpressure of its own; the enables come from the fetch control.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  if_id_t cur_q;
  if_id_t nxt;

  always_comb begin
    nxt = cur_q;
    if (bubble) begin
      nxt.instr = NOP_INSTR;
      nxt.pc4   = 32'h0;
      nxt.valid = 1'b0;
    end else if (load) begin
      nxt.instr = load_instr;
      nxt.pc4   = load_pc4;
      nxt.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
    end else begin
      cur_q <= nxt;
    end
  end

  assign instr = cur_q.instr;
  assign pc4   = cur_q.pc4;
  assign valid = cur_q.valid;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch-stage PC, RUN/HALT debug FSM and stall counter; all updates land one cycle later.
// Hazard enables hold PC / IF/ID; resolved branches override them; HALT freezes everything.
module fetch_stage_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        flush,
  input  logic        branch_resolved,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        brk,
  input  logic        resume,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] stall_count
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [15:0] stall_next;
  logic        ifid_load;
  logic        ifid_bubble;

  assign pc_plus4 = pc + PC_INC;
  assign halted   = (state == HALT);

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    stall_next  = stall_count;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state)
      RUN: begin
        // brk still lets this cycle's fetch/redirect complete; resume is ignored here.
        if (brk) state_next = HALT;
        if (branch_resolved) begin
          if (branch_taken) begin
            pc_next     = align_pc(branch_target);
            ifid_bubble = 1'b1;
          end else begin
            pc_next   = pc_plus4;
            ifid_load = 1'b1;
          end
        end else begin
          if (pc_write) begin
            pc_next = pc_plus4;
          end else if (stall_count != 16'hFFFF) begin
            stall_next = stall_count + 16'd1;
          end
          if (flush) begin
            ifid_bubble = 1'b1;
          end else if (if_id_write) begin
            ifid_load = 1'b1;
          end
        end
      end
      HALT: begin
        if (resume) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      stall_count <= 16'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      stall_count <= stall_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .load_instr (imem_instr),
    .load_pc4   (pc_plus4),
    .instr      (if_id_instr),
    .pc4        (if_id_pc4),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed plus randomized checks of fetch_stage_ctrl against a behavioural model.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0;
  logic        if_id_write = 1'b0;
  logic        flush = 1'b0;
  logic        branch_resolved = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        brk = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] imem_instr = 32'h0;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_halt;
  int          m_stall;

  fetch_stage_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .flush           (flush),
    .branch_resolved (branch_resolved),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .brk             (brk),
    .resume          (resume),
    .imem_instr      (imem_instr),
    .pc              (pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc4", if_id_pc4, m_pc4);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    chk("halted", {31'h0, halted}, {31'h0, m_halt});
    chk("stall_count", {16'h0, stall_count}, m_stall);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_halt = 1'b0; m_stall = 0;
  endtask

  // One clock of the fetch stage, written from the behavioural rules.
  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (m_halt) begin
      if (resume) m_halt = 1'b0;
    end else begin
      if (branch_resolved && branch_taken) begin
        m_pc = (branch_target / 4) * 4;
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (branch_resolved) begin
        m_pc = seq;
        m_instr = imem_instr; m_pc4 = seq; m_valid = 1;
      end else begin
        if (pc_write) m_pc = seq;
        else if (m_stall < 65535) m_stall = m_stall + 1;
        if (flush) begin
          m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (if_id_write) begin
          m_instr = imem_instr; m_pc4 = seq; m_valid = 1;
        end
      end
      if (brk) m_halt = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    pc_write = 0; if_id_write = 0; flush = 0; branch_resolved = 0;
    branch_taken = 0; brk = 0; resume = 0;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    idle_inputs();
    branch_resolved = 1; branch_taken = 1; branch_target = addr;
    tick();
    idle_inputs();
  endtask

  task automatic rand_inputs(input bit allow_dbg);
    pc_write = 1'($urandom);
    if_id_write = 1'($urandom);
    flush = ($urandom_range(0, 3) == 0);
    branch_resolved = ($urandom_range(0, 3) == 0);
    branch_taken = 1'($urandom);
    branch_target = $urandom;
    imem_instr = $urandom;
    brk = allow_dbg && ($urandom_range(0, 15) == 0);
    resume = allow_dbg && ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int stall0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_all();

    // Straight-line fetch
    pc_write = 1; if_id_write = 1; imem_instr = 32'h2008_0005;
    tick(); chk("seq_pc1", pc, 32'h4); chk("seq_pc4_1", if_id_pc4, 32'h4);
    tick(); chk("seq_pc2", pc, 32'h8);
    tick(); chk("seq_pc3", pc, 32'hC); chk("seq_pc4_3", if_id_pc4, 32'hC);
    chk("seq_valid", {31'h0, if_id_valid}, 32'h1);

    // Stall then flush
    jump_to(32'h40);
    pc_write = 1; if_id_write = 1; imem_instr = 32'h1234_5678;
    tick();
    jump_to(32'h40);
    stall0 = m_stall;
    tick(); chk("stall_pc_a", pc, 32'h40); chk("stall_hold", if_id_instr, 32'h0);
    flush = 1;
    tick(); chk("stall_pc_b", pc, 32'h40); chk("flush_valid", {31'h0, if_id_valid}, 32'h0);
    chk("stall_plus2", {16'h0, stall_count}, stall0 + 2);

    // Taken branch with misaligned target
    jump_to(32'h44);
    branch_resolved = 1; branch_taken = 1; branch_target = 32'h103; flush = 0;
    tick(); chk("taken_pc", pc, 32'h100); chk("taken_valid", {31'h0, if_id_valid}, 32'h0);

    // Not-taken branch ignores pc_write=0
    jump_to(32'h44);
    branch_resolved = 1; branch_taken = 0; imem_instr = 32'hAC01_0000;
    tick(); chk("nt_pc", pc, 32'h48); chk("nt_instr", if_id_instr, 32'hAC01_0000);
    chk("nt_pc4", if_id_pc4, 32'h48);

    // brk together with a taken branch, then HALT ignores everything
    idle_inputs();
    branch_resolved = 1; branch_taken = 1; branch_target = 32'h200; brk = 1; resume = 1;
    tick(); chk("brk_pc", pc, 32'h200); chk("brk_halted", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      rand_inputs(1'b0);
      brk = 1'($urandom);
      tick();
    end
    chk("halt_pc", pc, 32'h200);
    idle_inputs(); resume = 1; pc_write = 1; flush = 1;
    tick(); chk("resume_pc", pc, 32'h200); chk("resume_run", {31'h0, halted}, 32'h0);
    idle_inputs(); pc_write = 1; if_id_write = 1;
    tick(); chk("resume_fetch", pc, 32'h204);

    // Randomized run with debug activity
    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b1);
      tick();
    end
    idle_inputs(); resume = 1;
    tick();

    // PC wrap
    jump_to(32'hFFFF_FFFC);
    pc_write = 1; if_id_write = 1; imem_instr = 32'hDEAD_BEEF;
    tick(); chk("wrap_pc", pc, 32'h0); chk("wrap_pc4", if_id_pc4, 32'h0);

    // Stall counter saturation
    idle_inputs();
    while (m_stall < 65535) begin
      flush = 1'($urandom);
      if_id_write = 1'($urandom);
      tick();
    end
    chk("sat_reach", {16'h0, stall_count}, 32'hFFFF);
    tick(); tick();
    chk("sat_hold", {16'h0, stall_count}, 32'hFFFF);

    // Reset while halted and mid-redirect
    jump_to(32'h300);
    brk = 1; tick();
    brk = 0;
    branch_resolved = 1; branch_taken = 1; branch_target = 32'h500; pc_write = 1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_pc", pc, 32'h0); chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_stall", {16'h0, stall_count}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle_inputs(); pc_write = 1; if_id_write = 1; imem_instr = 32'h0000_0020;
    tick(); chk("post_rst_pc", pc, 32'h4); chk("post_rst_instr", if_id_instr, 32'h0000_0020);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage_ctrl.md
FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 pc_write  in  1  hazard-unit PC enable; 0 = hold PC.
REQ-005 if_id_write  in  1  hazard-unit IF/ID enable; 0 = hold IF/ID.
REQ-006 flush  in  1  hazard-unit request to load a bubble into IF/ID.
REQ-007 branch_resolved  in  1  EX/MEM stage holds a resolved branch this cycle.
REQ-008 branch_taken  in  1  resolved branch outcome; valid only with branch_resolved.
REQ-009 branch_target  in  32  resolved branch destination address.
REQ-010 brk  in  1  debug halt request, single-cycle pulse.
REQ-011 resume  in  1  debug resume request, single-cycle pulse.
REQ-012 imem_instr  in  32  instruction word returned combinationally for pc.
REQ-013 pc  out  32  current fetch address to instruction memory.
REQ-014 if_id_instr  out  32  IF/ID instruction register.
REQ-015 if_id_pc4  out  32  IF/ID register holding fetch address + 4.
REQ-016 if_id_valid  out  1  IF/ID holds a real instruction, not a bubble.
REQ-017 halted  out  1  block is in HALT state.
REQ-018 stall_count  out  16  saturating count of hazard-stall cycles.

Function
REQ-019 States SHALL be RUN and HALT; halted SHALL equal (state == HALT).
REQ-020 In RUN, if branch_resolved && branch_taken: pc <= {branch_target[31:2],2'b00}; IF/ID <= bubble (instr 32'h0, pc4 32'h0, valid 0), regardless of pc_write, if_id_write, flush.
REQ-021 In RUN, if branch_resolved && !branch_taken: pc <= pc+4; IF/ID <= {imem_instr, pc+4, valid 1}, regardless of pc_write, if_id_write, flush.
REQ-022 In RUN without branch_resolved: pc <= pc+4 only when pc_write=1, else hold.
REQ-023 In RUN without branch_resolved: flush=1 loads bubble; else if_id_write=1 loads {imem_instr, pc+4, 1}; else IF/ID holds; flush SHALL win over if_id_write.
REQ-024 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0.
REQ-025 brk=1 in RUN SHALL move state to HALT next cycle; that cycle's PC/IF/ID update (including any branch redirect) SHALL still complete.
REQ-026 In HALT, pc, IF/ID and stall_count SHALL hold; pc_write, if_id_write, flush, branch_* SHALL be ignored.
REQ-027 resume=1 in HALT SHALL return to RUN next cycle with no PC/IF/ID change that cycle; brk in HALT and resume in RUN SHALL be ignored; brk and resume together in RUN SHALL act as brk.
REQ-028 stall_count SHALL increment in RUN when pc_write=0 and branch_resolved=0, saturating at 16'hFFFF.
REQ-029 All outputs SHALL be registered except halted, which decodes state directly.

Reset
REQ-030 rst_n low SHALL asynchronously set pc=32'h0000_0000, IF/ID to bubble (instr 0, pc4 0, valid 0), stall_count=0, state=RUN.
REQ-031 Reset asserted mid-operation (including in HALT or during a redirect) SHALL discard all pending activity; the first rising edge after release SHALL behave as a RUN cycle from pc 0.

Structure
REQ-032 Shared package mips_pkg SHALL hold NOP_INSTR (32'h0), RESET_PC (32'h0), PC_INC (4) and the RUN/HALT state encoding.
REQ-033 The IF/ID register set (instr, pc4, valid with load/bubble/hold controls) SHALL be a sub-module named if_id_reg; PC, state machine and counter stay in fetch_stage_ctrl.

Verification
REQ-034 Reset then 3 cycles pc_write=if_id_write=1, imem_instr=32'h2008_0005 -> pc 0,4,8,C; if_id_pc4=4,8,C; valid=1.
REQ-035 pc=32'h40, pc_write=if_id_write=0 for 2 cycles, flush=1 on the second -> pc stays 32'h40; IF/ID holds then becomes bubble; stall_count +2.
REQ-036 pc=32'h44, branch_resolved=1, branch_taken=1, branch_target=32'h103, pc_write=0 -> next pc=32'h100; IF/ID valid=0.
REQ-037 pc=32'h44, branch_resolved=1, branch_taken=0, pc_write=0, imem_instr=32'hAC01_0000 -> pc=32'h48; if_id_instr=32'hAC01_0000, if_id_pc4=32'h48.
REQ-038 brk with taken branch to 32'h200 -> pc=32'h200, halted=1; 5 cycles of stimulus change nothing; resume -> RUN, fetch continues from 32'h200.
REQ-039 pc=32'hFFFF_FFFC, pc_write=1 -> pc=32'h0; stall_count preset to 16'hFFFF with pc_write=0 -> stays 16'hFFFF; rst_n pulsed low in HALT -> all outputs at reset values immediately.
